// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel receive stage.
// Holding-register state encoding and the bit-counter width helper live here.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  // Floor of one bit so a degenerate WIDTH still yields a legal vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Bus bundle between the deserializer and its serial source / parallel consumer.
// The master side drives serial bits and the handshake; the slave side is the deserializer.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int CNT_W = cnt_width(WIDTH);

  logic             sin;
  logic             sin_en;
  logic             sync_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             ovr_clr;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output sin,
    output sin_en,
    output sync_clr,
    output dout_ready,
    output ovr_clr,
    input  dout,
    input  dout_valid,
    input  overrun,
    input  bit_cnt
  );

  modport slave (
    input  sin,
    input  sin_en,
    input  sync_clr,
    input  dout_ready,
    input  ovr_clr,
    output dout,
    output dout_valid,
    output overrun,
    output bit_cnt
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH position counter for the word being assembled.
// last_bit_o marks the edge on which the final bit of a word is sampled.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_bit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_W'(WIDTH - 1));

  // A framing restart swallows any strobe on the same edge, so it never completes a word.
  assign last_bit_o = en_i & ~clr_i & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receive stage: assembles WIDTH-bit words from a strobed bit stream
// and hands them to a consumer through a single-entry holding register with sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  sipo_deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  hold_state_t      hold_q;
  logic [WIDTH-1:0] dout_q;
  logic             overrun_q;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (bus.sin_en),
    .clr_i      (bus.sync_clr),
    .cnt_o      (bit_cnt),
    .last_bit_o (last_bit)
  );

  // The shifted value already holds the current bit, so it is the completed word on last_bit.
  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {shift_q[WIDTH-2:0], bus.sin};
  end else begin : g_lsb_first
    assign shifted = {bus.sin, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    shift_d = shift_q;
    if (bus.sync_clr) begin
      shift_d = '0;
    end else if (bus.sin_en) begin
      shift_d = shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // Holding register: a handshake and a completion on one edge replace the word in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= HOLD_EMPTY;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (hold_q)
        HOLD_EMPTY: begin
          if (last_bit) begin
            hold_q <= HOLD_FULL;
            dout_q <= shifted;
          end
        end
        HOLD_FULL: begin
          if (bus.dout_ready) begin
            if (last_bit) begin
              dout_q <= shifted;
            end else begin
              hold_q <= HOLD_EMPTY;
            end
          end
        end
        default: hold_q <= HOLD_EMPTY;
      endcase

      if ((hold_q == HOLD_FULL) && !bus.dout_ready && last_bit) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (hold_q == HOLD_FULL);
  assign bus.overrun    = overrun_q;
  assign bus.bit_cnt    = bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: MSB-first and LSB-first deserializers fed the same stream,
// checked every cycle against a queue-based word model plus directed known words.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;

  logic clk;
  logic rstN;

  int checkCount;
  int passCount;

  sipo_deserializer_if #(.WIDTH(WIDTH)) ifM ();
  sipo_deserializer_if #(.WIDTH(WIDTH)) ifL ();

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutM (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (ifM)
  );

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutL (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (ifL)
  );

  assign ifL.sin        = ifM.sin;
  assign ifL.sin_en     = ifM.sin_en;
  assign ifL.sync_clr   = ifM.sync_clr;
  assign ifL.dout_ready = ifM.dout_ready;
  assign ifL.ovr_clr    = ifM.ovr_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits received so far in the partial word, in arrival order.
  bit             bits[$];
  logic [WIDTH-1:0] expDoutM;
  logic [WIDTH-1:0] expDoutL;
  logic           expValid;
  logic           expOvr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic resetModel();
    bits.delete();
    expDoutM = '0;
    expDoutL = '0;
    expValid = 1'b0;
    expOvr   = 1'b0;
  endtask

  task automatic modelStep(input logic s, input logic en, input logic clr, input logic rdy, input logic oc);
    logic             done;
    logic             accepted;
    logic             newOvr;
    logic [WIDTH-1:0] wM;
    logic [WIDTH-1:0] wL;
    done     = 1'b0;
    newOvr   = 1'b0;
    wM       = '0;
    wL       = '0;
    accepted = expValid && rdy;
    if (clr) begin
      bits.delete();
    end else if (en) begin
      bits.push_back(s);
      if (bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) begin
          wM[WIDTH-1-i] = bits[i];
          wL[i]         = bits[i];
        end
        done = 1'b1;
        bits.delete();
      end
    end
    if (done) begin
      if (!expValid || accepted) begin
        expValid = 1'b1;
        expDoutM = wM;
        expDoutL = wL;
      end else begin
        newOvr = 1'b1;
      end
    end else if (accepted) begin
      expValid = 1'b0;
    end
    if (newOvr) expOvr = 1'b1;
    else if (oc) expOvr = 1'b0;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".doutMsb"},   32'(ifM.dout),       32'(expDoutM));
    checkOutput({tag, ".doutLsb"},   32'(ifL.dout),       32'(expDoutL));
    checkOutput({tag, ".validMsb"},  32'(ifM.dout_valid), 32'(expValid));
    checkOutput({tag, ".validLsb"},  32'(ifL.dout_valid), 32'(expValid));
    checkOutput({tag, ".ovrMsb"},    32'(ifM.overrun),    32'(expOvr));
    checkOutput({tag, ".ovrLsb"},    32'(ifL.overrun),    32'(expOvr));
    checkOutput({tag, ".bitCntMsb"}, 32'(ifM.bit_cnt),    32'(bits.size()));
    checkOutput({tag, ".bitCntLsb"}, 32'(ifL.bit_cnt),    32'(bits.size()));
  endtask

  // One clock: drive inputs, take the edge, advance the model and compare.
  task automatic applyStimulus(input logic s, input logic en, input logic clr, input logic rdy, input logic oc);
    ifM.sin        = s;
    ifM.sin_en     = en;
    ifM.sync_clr   = clr;
    ifM.dout_ready = rdy;
    ifM.ovr_clr    = oc;
    @(posedge clk);
    #1;
    modelStep(s, en, clr, rdy, oc);
    compareAll("cyc");
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input bit useGaps, input logic rdy,
                          input logic lastRdy, input logic lastOc);
    int g;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (useGaps) begin
        g = $urandom_range(1, 3);
        repeat (g) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      end
      applyStimulus(w[i], 1'b1, 1'b0, (i == 0) ? lastRdy : rdy, (i == 0) ? lastOc : 1'b0);
    end
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    rstN           = 1'b0;
    ifM.sin        = 1'b0;
    ifM.sin_en     = 1'b0;
    ifM.sync_clr   = 1'b0;
    ifM.dout_ready = 1'b0;
    ifM.ovr_clr    = 1'b0;
    resetModel();

    repeat (6) #2 ifM.sin = ~ifM.sin;
    compareAll("reset");
    rstN = 1'b1;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    sendWord(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("basicMsb", 32'(ifM.dout), 32'h0000000B);
    checkOutput("basicLsb", 32'(ifL.dout), 32'h0000000D);
    checkOutput("basicValid", 32'(ifM.dout_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("oneCycleValid", 32'(ifM.dout_valid), 32'd0);

    sendWord(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stallStable", 32'(ifM.dout), 32'h0000000B);
    checkOutput("stallValid", 32'(ifM.dout_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stallAccept", 32'(ifM.dout_valid), 32'd0);

    sendWord(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    sendWord(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovrKeepWord", 32'(ifM.dout), 32'h0000000B);
    checkOutput("ovrSet", 32'(ifM.overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovrClear", 32'(ifM.overrun), 32'd0);
    sendWord(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovrSetWins", 32'(ifM.overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    sendWord(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("gapFirst", 32'(ifM.dout), 32'h0000000B);
    sendWord(4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("gapSecondMsb", 32'(ifM.dout), 32'h00000005);
    checkOutput("gapSecondLsb", 32'(ifL.dout), 32'h0000000A);
    checkOutput("gapNoOvr", 32'(ifM.overrun), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sendWord(4'b0110, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("syncClrWord", 32'(ifM.dout), 32'h00000006);

    sendWord(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    sendWord(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ifM.sin_en = 1'b0;
    #3 rstN = 1'b0;
    #1;
    resetModel();
    compareAll("asyncRst");
    checkOutput("asyncRstDout", 32'(ifM.dout), 32'd0);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;
    compareAll("postRst");
    sendWord(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("postRstWord", 32'(ifM.dout), 32'h00000009);

    for (int c = 0; c < 800; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-to-parallel receive stage that sits directly downstream of the team's PISO shift register.
- Samples the PISO serial output one bit per enabled clock and assembles WIDTH-bit words.
- Presents each completed word on a parallel output with a valid/ready handshake; a single-entry holding register decouples capture from the consumer.
- Detects overrun when the consumer stalls and flags it as a sticky status.

Parameters:
- WIDTH, 4, bits per word; must be >= 2. Matches the PISO load width.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1] (PISO shifts MSB out first); 0: first bit lands in dout[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data in; connects to PISO dout.
- sin_en  input  1  bit strobe; sin is sampled on rising clk only when sin_en=1.
- sync_clr  input  1  synchronous framing restart; discards the partial word.
- dout  output  WIDTH  assembled word in the holding register.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
- overrun  output  1  sticky; a completed word was dropped because the holding register was full.
- ovr_clr  input  1  synchronous clear of overrun.
- bit_cnt  output  $clog2(WIDTH)  number of bits captured in the current partial word.

Behaviour:
- Reset: rst=0 asynchronously forces shift_reg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0. These values hold while rst=0.
- Capture: on a clk edge with sin_en=1, shift sin into shift_reg and increment bit_cnt.
  - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shift_reg <= {sin, shift_reg[WIDTH-1:1]}.
- Word completion: when sin_en=1 and bit_cnt==WIDTH-1, the completed word (including the current sin) is offered to the holding register on that same edge. bit_cnt wraps to 0.
- Latency: dout/dout_valid update on the edge that samples the last bit, i.e. one clk after that bit is presented.
- Holding register FSM:
  - States: EMPTY (dout_valid=0) and FULL (dout_valid=1).
  - EMPTY + word completes -> FULL, dout loaded.
  - FULL + handshake (dout_valid & dout_ready), no completion -> EMPTY.
  - FULL + handshake + completion on the same edge -> stays FULL, dout loaded with the new word. No overrun.
  - FULL + no handshake + completion -> stays FULL, dout unchanged, new word dropped, overrun <= 1.
- dout is stable while dout_valid=1 and no handshake occurs.
- overrun:
  - Cleared only by ovr_clr=1 or reset.
  - ovr_clr and a new overrun on the same edge -> overrun=1 (set wins).
- sync_clr=1: bit_cnt <= 0 and shift_reg <= 0; any sin_en bit on that edge is ignored. Holding register and overrun are unaffected.
- sin_en=0: shift_reg and bit_cnt hold. Gaps between bits are legal and of any length.
- Reset asserted mid-word or with dout_valid=1: all state is lost. After release, capture restarts at bit 0.
- Reset release is asynchronous; the first capture occurs on the first clk edge with rst=1 and sin_en=1.

Decomposition:
- Shared package sipo_pkg:
  - localparam DEFAULT_WIDTH=4.
  - Holding-state typedef hold_state_t {HOLD_EMPTY, HOLD_FULL}.
  - Function cnt_width(WIDTH) returning $clog2(WIDTH), used for bit_cnt sizing.
- One sub-module, sipo_bit_counter:
  - Modulo-WIDTH counter with enable (sin_en) and sync clear (sync_clr).
  - Outputs bit_cnt and a last_bit pulse (en & cnt==WIDTH-1).
- Shift register, holding register and overrun logic stay in sipo_deserializer.

Test Plan:
- Reset/idle: rst=0 for 12 ns with sin toggling -> dout=0000, dout_valid=0, overrun=0, bit_cnt=0. After release with sin_en=0 for 5 cycles -> no change.
- Basic word (WIDTH=4, MSB_FIRST=1, dout_ready=1): sin_en=1 for 4 cycles with sin=1,0,1,1 -> dout=1011, dout_valid=1 for exactly one cycle after the 4th edge, bit_cnt back to 0. Repeat with MSB_FIRST=0 -> dout=1101.
- Stall then accept: dout_ready=0; send 1011 -> dout_valid=1 held, dout=1011 stable. Raise dout_ready for one cycle -> dout_valid=0 next edge.
- Overrun: dout_ready=0; send 1011 then 0110 -> dout stays 1011, overrun=1 after the 8th bit. Pulse ovr_clr -> overrun=0. Repeat with ovr_clr coincident with the overrun edge -> overrun=1.
- Back-to-back with gaps: send 1011 then 0101, dout_ready asserted exactly on the completion edge of the second word, sin_en with random 1–3 cycle gaps -> dout=1011 then 0101, no overrun.
- Mid-word disruption: send 2 bits (1,0), then sync_clr=1, then 0110 -> dout=0110. Send 3 bits, assert rst=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, 1001 -> dout=1001.
